ecc_enc_pipe: RTL
=================

Name: ecc_enc_pipe

Overview:
Parametrised extended-Hamming (SEC-DED) encoder with NUM_MODES codeword geometries. It takes raw right-aligned info bits and computes every Hamming parity bit plus the overall parity bit. It emits a zero-padded codeword through a 2-stage valid/ready pipeline with full backpressure. It replaces the fixed three-mode, single-parity encoder stage at the head of the ECC encode path.

Parameters:
NUM_MODES, 3, number of supported geometries; mode m: n_m=2^(m+3), r_m=m+4 parity bits (incl. overall), k_m=n_m-r_m info bits
MAX_CODEWORD_WIDTH, 2^(NUM_MODES+2), localparam, widest codeword (32 at default)
MAX_INFO_WIDTH, MAX_CODEWORD_WIDTH-NUM_MODES-3, localparam (26 at default)
MODE_WIDTH, 2, width of mode port; must satisfy 2^MODE_WIDTH >= NUM_MODES
CNT_WIDTH, 16, width of accepted-codeword counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
info_in  in  MAX_INFO_WIDTH  info bits, right-aligned; bits >= k_mode ignored
mode  in  MODE_WIDTH  geometry select, sampled with info_in
out_valid  out  1  codeword valid
out_ready  in  1  downstream accepts codeword
codeword_out  out  MAX_CODEWORD_WIDTH  encoded word, zero-padded above n_mode
out_err  out  1  word was submitted with illegal mode (mode >= NUM_MODES)
cw_count  out  CNT_WIDTH  saturating count of output handshakes

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, codeword_out=0, out_err=0, cw_count=0; in_ready=1 during and after reset. Reset mid-stream drops all in-flight words.
- Handshake: transfer when valid&&ready on the same edge. out_valid/codeword_out/out_err are held stable while out_valid&&!out_ready. in_ready may depend combinationally on out_ready, but in_valid must not.
- Pipeline: stage1 accept = !s1_valid || s2_adv; s2_adv = !s2_valid || out_ready; in_ready = stage1 accept. Latency 2 cycles from input handshake to out_valid, with no bubbles. Throughput is 1 word/cycle under continuous out_ready=1.
- Stage 1 registers mode, masked info and the Hamming parity p[r-2:0]. Stage 2 registers the overall parity and the assembled codeword.
- Codeword layout for mode m: info_in[k-1:0] occupies bits [n-1:r]; bit r-1 is the overall parity; bits [r-2:0] hold Hamming parity p_j at bit j.
- Column rule: info positions take all (r-1)-bit vectors of weight >= 2 in descending binary order. The highest codeword position (info_in[k-1]) gets the largest vector. p_j is the XOR of info bits whose vector has bit j set.
- Overall parity: XOR of all other codeword bits (even parity over n bits).
- Bits [MAX_CODEWORD_WIDTH-1:n] are 0.
- Illegal mode: the word is accepted and pipelined normally; the output has codeword_out=0 and out_err=1.
- cw_count increments on every output handshake, including errored words. It saturates at all-ones and never wraps.
- Simultaneous input and output handshake on a full pipeline: both occur, and the pipeline stays full.

Test Plan:
1. Mode 0, info_in=0x0B, out_ready=1 -> two cycles later out_valid=1, codeword_out=0x000000B1, out_err=0, cw_count=1.
2. Mode 1, info_in=0x001 -> codeword_out=0x00000033; then mode 2, info_in=0x3FFFFFF back-to-back -> codeword_out=0xFFFFFFFF on the next cycle, with no bubble.
3. Mode 3 (illegal), info_in=0x3FFFFFF -> codeword_out=0, out_err=1, cw_count increments.
4. Backpressure: out_ready=0, offer 3 words (0x1, 0x2, 0x3, mode 0).
   - in_ready drops after 2 accepts.
   - codeword_out holds the value for word 0x1 unchanged.
   - Raise out_ready -> outputs appear in order 0x1, 0x2, 0x3 with no loss or duplication.
5. Reset mid-operation: pipeline full, assert rst asynchronously between edges -> out_valid=0, codeword_out=0, cw_count=0 immediately. After release, the first new word appears 2 cycles after its accept.
6. Counter saturation: with CNT_WIDTH=4, do 20 output handshakes -> cw_count stops at 0xF.

Source files
------------

// File: rtl/ecc_enc_pipe_if.sv
// Valid/ready bus for the SEC-DED encoder: info/mode request side and codeword response side.
// Widths are derived from the same geometry parameters as the encoder.
interface ecc_enc_pipe_if #(
    parameter int NUM_MODES  = 3,
    parameter int MODE_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
);
    localparam int CW_W   = 2 ** (NUM_MODES + 2);
    localparam int INFO_W = CW_W - NUM_MODES - 3;

    logic                  in_valid;
    logic                  in_ready;
    logic [INFO_W-1:0]     info_in;
    logic [MODE_WIDTH-1:0] mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW_W-1:0]       codeword_out;
    logic                  out_err;
    logic [CNT_WIDTH-1:0]  cw_count;

    modport slave (
        input  in_valid, info_in, mode, out_ready,
        output in_ready, out_valid, codeword_out, out_err, cw_count
    );

    modport master (
        output in_valid, info_in, mode, out_ready,
        input  in_ready, out_valid, codeword_out, out_err, cw_count
    );
endinterface

// File: rtl/ecc_enc_pipe.sv
// Extended-Hamming (SEC-DED) encoder, NUM_MODES geometries, 2-stage valid/ready pipeline.
// ecc_enc_par computes the Hamming parity for one geometry; the top selects by mode.
module ecc_enc_par #(
    parameter int MODE   = 0,
    parameter int INFO_W = 26,
    parameter int PAR_W  = 5
) (
    input  logic [INFO_W-1:0] info,
    output logic [PAR_W-1:0]  par
);
    localparam int RH = MODE + 3;

    // Info bit i takes the i-th smallest RH-bit vector of weight >= 2, so the
    // top info bit gets the all-ones column.
    function automatic logic [INFO_W-1:0] col_mask(input int j);
        logic [INFO_W-1:0] msk;
        int                idx;
        msk = '0;
        idx = 0;
        for (int v = 3; v < (1 << RH); v++) begin
            if ($countones(v) >= 2) begin
                if (idx < INFO_W && ((v >> j) & 1) != 0) msk[idx] = 1'b1;
                idx++;
            end
        end
        return msk;
    endfunction

    for (genvar j = 0; j < PAR_W; j++) begin : g_bit
        if (j < RH) begin : g_on
            localparam logic [INFO_W-1:0] MSK = col_mask(j);
            assign par[j] = ^(info & MSK);
        end else begin : g_off
            assign par[j] = 1'b0;
        end
    end
endmodule

module ecc_enc_pipe #(
    parameter int NUM_MODES  = 3,
    parameter int MODE_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input logic           clk,
    input logic           rst,
    ecc_enc_pipe_if.slave bus
);
    localparam int MAX_CODEWORD_WIDTH = 2 ** (NUM_MODES + 2);
    localparam int MAX_INFO_WIDTH     = MAX_CODEWORD_WIDTH - NUM_MODES - 3;
    localparam int PAR_W              = NUM_MODES + 2;

    function automatic logic [MAX_INFO_WIDTH-1:0] info_mask(input logic [MODE_WIDTH-1:0] md);
        logic [MAX_INFO_WIDTH-1:0] msk;
        int                        k;
        msk = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (md == MODE_WIDTH'(m)) begin
                k = (1 << (m + 3)) - m - 4;
                for (int b = 0; b < MAX_INFO_WIDTH; b++) msk[b] = (b < k);
            end
        end
        return msk;
    endfunction

    logic                                 mode_ok;
    logic [MAX_INFO_WIDTH-1:0]            info_msk;
    logic [NUM_MODES-1:0][PAR_W-1:0]      par_m;
    logic [PAR_W-1:0]                     par_sel;
    logic                                 s1_acc, s2_adv, ovr;
    logic [MAX_CODEWORD_WIDTH-1:0]        cw_asm;

    logic                                 s1_valid_q, s1_valid_d;
    logic                                 s1_err_q, s1_err_d;
    logic [MODE_WIDTH-1:0]                s1_mode_q, s1_mode_d;
    logic [MAX_INFO_WIDTH-1:0]            s1_info_q, s1_info_d;
    logic [PAR_W-1:0]                     s1_par_q, s1_par_d;
    logic                                 s2_valid_q, s2_valid_d;
    logic                                 s2_err_q, s2_err_d;
    logic [MAX_CODEWORD_WIDTH-1:0]        s2_cw_q, s2_cw_d;
    logic [CNT_WIDTH-1:0]                 cw_count_q, cw_count_d;

    // Illegal modes mask info to zero, so parity and codeword fall out as zero.
    assign mode_ok  = int'(bus.mode) < NUM_MODES;
    assign info_msk = bus.info_in & info_mask(bus.mode);

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        ecc_enc_par #(
            .MODE   (m),
            .INFO_W (MAX_INFO_WIDTH),
            .PAR_W  (PAR_W)
        ) u_par (
            .info (info_msk),
            .par  (par_m[m])
        );
    end

    always_comb begin
        par_sel = '0;
        for (int m = 0; m < NUM_MODES; m++)
            if (bus.mode == MODE_WIDTH'(m)) par_sel = par_m[m];
    end

    // Layout: info above bit r, overall parity at r-1, Hamming parity below (r = mode+4).
    assign ovr    = ^{s1_info_q, s1_par_q};
    assign cw_asm = (MAX_CODEWORD_WIDTH'(s1_info_q) << (int'(s1_mode_q) + 4))
                  | (MAX_CODEWORD_WIDTH'(ovr) << (int'(s1_mode_q) + 3))
                  | MAX_CODEWORD_WIDTH'(s1_par_q);

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_acc       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_acc;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_err_d   = s1_err_q;
        s1_mode_d  = s1_mode_q;
        s1_info_d  = s1_info_q;
        s1_par_d   = s1_par_q;
        s2_valid_d = s2_valid_q;
        s2_err_d   = s2_err_q;
        s2_cw_d    = s2_cw_q;
        cw_count_d = cw_count_q;

        if (s1_acc) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_err_d  = !mode_ok;
                s1_mode_d = bus.mode;
                s1_info_d = info_msk;
                s1_par_d  = par_sel;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_err_d = s1_err_q;
                s2_cw_d  = s1_err_q ? '0 : cw_asm;
            end
        end

        if (s2_valid_q && bus.out_ready && cw_count_q != '1)
            cw_count_d = cw_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_mode_q  <= '0;
            s1_info_q  <= '0;
            s1_par_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_cw_q    <= '0;
            cw_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_mode_q  <= s1_mode_d;
            s1_info_q  <= s1_info_d;
            s1_par_q   <= s1_par_d;
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_cw_q    <= s2_cw_d;
            cw_count_q <= cw_count_d;
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.codeword_out = s2_cw_q;
    assign bus.out_err      = s2_err_q;
    assign bus.cw_count     = cw_count_q;
endmodule
